boot_controller: RTL and testbench

Boot sequencer and bus owner for the single-cycle RISC-V core's data bus. After reset it holds the core in reset and copies a fixed-size image, one word per cycle, from a combinational ROM port into the RAM over the shared data bus. It then reads the image back and verifies it. On success it hands the bus to the core and releases the core's reset; on a mismatch it parks in an error state.

---
 rtl/boot_pkg.sv | 29 ++
 rtl/boot_bus_mux.sv | 22 ++
 rtl/boot_controller.sv | 123 ++++++++++++
 tb/tb_boot_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader and its data-bus mux.
package boot_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COPY   = 3'd1,
    VERIFY = 3'd2,
    RUN    = 3'd3,
    ERROR  = 3'd4
  } boot_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              write;
    logic              read;
  } bus_req_t;

  // Byte address of word `index` above `base`; wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] word_address(input logic [ADDR_W-1:0] base,
                                                     input logic [ADDR_W-1:0] index);
    return base + index * ADDR_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/boot_bus_mux.sv
// Selects the RAM bus driver: loader while booting, the core while running.
module boot_bus_mux
  import boot_pkg::*;
(
  input  logic              run_sel,
  input  bus_req_t          loader,
  input  bus_req_t          core,
  input  logic [DATA_W-1:0] ram_read_data,
  output bus_req_t          bus,
  output logic [DATA_W-1:0] core_read_data
);

  always_comb begin
    bus            = loader;
    core_read_data = '0;
    if (run_sel) begin
      bus            = core;
      core_read_data = ram_read_data;
    end
  end

endmodule

// File: rtl/boot_controller.sv
// Boot sequencer: copies a ROM image into RAM, verifies it, then hands the
// data bus to the core and releases its reset.
module boot_controller
  import boot_pkg::*;
#(
  parameter int unsigned WORDS    = 16,
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h0000_0100,
  parameter int unsigned CNT_W    = $clog2(WORDS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [31:0]      src_address,
  input  logic [31:0]      src_data,
  input  logic [31:0]      core_bus_address,
  input  logic [31:0]      core_bus_write_data,
  input  logic             core_bus_write,
  input  logic             core_bus_read,
  output logic [31:0]      core_bus_read_data,
  output logic [31:0]      bus_address,
  output logic [31:0]      bus_write_data,
  output logic             bus_write,
  output logic             bus_read,
  input  logic [31:0]      bus_read_data,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  boot_state_t      state, state_next;
  logic [CNT_W-1:0] idx, idx_next;
  logic             last;
  bus_req_t         loader, core, bus;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next state, index update and loader bus drive.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    loader      = '0;
    src_address = SRC_BASE;
    last        = (idx == CNT_W'(WORDS - 1));
    case (state)
      IDLE: begin
        state_next = COPY;
        idx_next   = '0;
      end
      COPY: begin
        src_address       = word_address(SRC_BASE, ADDR_W'(idx));
        loader.address    = word_address(DST_BASE, ADDR_W'(idx));
        loader.write_data = src_data;
        loader.write      = 1'b1;
        if (last) begin
          state_next = VERIFY;
          idx_next   = '0;
        end else begin
          idx_next = idx + CNT_W'(1);
        end
      end
      VERIFY: begin
        src_address    = word_address(SRC_BASE, ADDR_W'(idx));
        loader.address = word_address(DST_BASE, ADDR_W'(idx));
        loader.read    = 1'b1;
        if (bus_read_data != src_data) begin
          state_next = ERROR;
        end else if (last) begin
          state_next = RUN;
        end else begin
          idx_next = idx + CNT_W'(1);
        end
      end
      RUN, ERROR: begin
        if (start) begin
          state_next = COPY;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign core = '{address:    core_bus_address,
                  write_data: core_bus_write_data,
                  write:      core_bus_write,
                  read:       core_bus_read};

  boot_bus_mux u_bus_mux (
    .run_sel        (state == RUN),
    .loader         (loader),
    .core           (core),
    .ram_read_data  (bus_read_data),
    .bus            (bus),
    .core_read_data (core_bus_read_data)
  );

  assign bus_address    = bus.address;
  assign bus_write_data = bus.write_data;
  assign bus_write      = bus.write;
  assign bus_read       = bus.read;

  // Status decodes straight from the state register.
  assign core_reset = (state != RUN);
  assign busy       = (state == COPY) || (state == VERIFY);
  assign done       = (state == RUN);
  assign error      = (state == ERROR);
  assign word_count = idx;

endmodule

// File: tb/tb_boot_controller.sv
// Bench for boot_controller: ROM/RAM models plus a scoreboard of expected
// loader bus transactions.
module tb_boot_controller;
  import boot_pkg::*;

  localparam int unsigned WORDS    = 4;
  localparam logic [31:0] SRC_BASE = 32'h0000_0000;
  localparam logic [31:0] DST_BASE = 32'h0000_0100;
  localparam int unsigned CNT_W    = $clog2(WORDS + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_address, src_data;
  logic [31:0]      core_bus_address    = '0;
  logic [31:0]      core_bus_write_data = '0;
  logic             core_bus_write      = 1'b0;
  logic             core_bus_read       = 1'b0;
  logic [31:0]      core_bus_read_data;
  logic [31:0]      bus_address, bus_write_data, bus_read_data;
  logic             bus_write, bus_read;
  logic             core_reset, busy, done, error;
  logic [CNT_W-1:0] word_count;

  always #5 clock = ~clock;

  boot_controller #(
    .WORDS    (WORDS),
    .SRC_BASE (SRC_BASE),
    .DST_BASE (DST_BASE)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .src_address         (src_address),
    .src_data            (src_data),
    .core_bus_address    (core_bus_address),
    .core_bus_write_data (core_bus_write_data),
    .core_bus_write      (core_bus_write),
    .core_bus_read       (core_bus_read),
    .core_bus_read_data  (core_bus_read_data),
    .bus_address         (bus_address),
    .bus_write_data      (bus_write_data),
    .bus_write           (bus_write),
    .bus_read            (bus_read),
    .bus_read_data       (bus_read_data),
    .core_reset          (core_reset),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .word_count          (word_count)
  );

  // Combinational ROM; out-of-image addresses return a recognisable pattern.
  logic [31:0] rom [WORDS] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] src_off;
  assign src_off  = (src_address - SRC_BASE) >> 2;
  assign src_data = (src_off < 32'(WORDS)) ? rom[src_off[1:0]] : (32'hBAD0_0000 | src_off);

  // RAM with an optional corrupted read at one address.
  bit   [31:0] ram [256];
  bit          corrupt_en   = 1'b0;
  logic [31:0] corrupt_addr = '0;
  always @(posedge clock) if (bus_write) ram[bus_address[9:2]] <= bus_write_data;
  assign bus_read_data = (corrupt_en && bus_read && bus_address == corrupt_addr) ? 32'h0
                                                                                : ram[bus_address[9:2]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] src;
    logic [31:0] data;
    int          idx;
  } exp_t;

  exp_t sbq[$];
  bit   loading = 1'b0;

  task automatic push_load(input int n_writes, input int n_reads);
    exp_t e;
    for (int i = 0; i < n_writes; i++) begin
      e.wr = 1'b1; e.addr = DST_BASE + 32'(i * 4); e.src = SRC_BASE + 32'(i * 4);
      e.data = rom[i]; e.idx = i;
      sbq.push_back(e);
    end
    for (int i = 0; i < n_reads; i++) begin
      e.wr = 1'b0; e.addr = DST_BASE + 32'(i * 4); e.src = SRC_BASE + 32'(i * 4);
      e.data = '0; e.idx = i;
      sbq.push_back(e);
    end
  endtask

  // Every loader transaction must match the next expected entry in order.
  always @(negedge clock) begin
    exp_t e;
    if (loading && (bus_write || bus_read)) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected", {30'b0, bus_write, bus_read}, 32'h0);
      end else begin
        e = sbq.pop_front();
        check("sb_kind", {30'b0, bus_write, bus_read}, e.wr ? 32'h2 : 32'h1);
        check("sb_addr", bus_address, e.addr);
        check("sb_src",  src_address, e.src);
        check("sb_idx",  32'(word_count), 32'(e.idx));
        if (e.wr) check("sb_data", bus_write_data, e.data);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    core_bus_address    = 32'hFFFF_FFF0;
    core_bus_write_data = 32'hA5A5_A5A5;
    core_bus_write      = 1'b1;
    core_bus_read       = 1'b1;

    // Reset state with core strobes active (must be ignored).
    step(2);
    check("rst_core_reset", 32'(core_reset), 32'h1);
    check("rst_bus_write",  32'(bus_write), 32'h0);
    check("rst_bus_read",   32'(bus_read), 32'h0);
    check("rst_bus_addr",   bus_address, 32'h0);
    check("rst_bus_wdata",  bus_write_data, 32'h0);
    check("rst_src_addr",   src_address, SRC_BASE);
    check("rst_status",     {29'b0, busy, done, error}, 32'h0);
    check("rst_core_rdata", core_bus_read_data, 32'h0);
    check("rst_idx",        32'(word_count), 32'h0);

    // Clean load with start held high through COPY.
    push_load(WORDS, WORDS);
    loading = 1'b1;
    #1 reset = 1'b1; start = 1'b1;
    #1 check("idle_bus_write", 32'(bus_write), 32'h0);
    for (int c = 0; c < int'(WORDS); c++) begin
      step(1);
      check("copy_busy", 32'(busy), 32'h1);
      check("copy_idx",  32'(word_count), 32'(c));
    end
    step(1);
    #1 start = 1'b0;
    step(WORDS - 1);
    check("verify_done_early", 32'(done), 32'h0);
    check("verify_busy",       32'(busy), 32'h1);
    #1 core_bus_write = 1'b0; core_bus_read = 1'b0;
    step(1);
    check("load_done",       32'(done), 32'h1);
    check("load_core_reset", 32'(core_reset), 32'h0);
    check("load_busy",       32'(busy), 32'h0);
    #1 loading = 1'b0;
    check("load_drain", 32'(sbq.size()), 32'h0);
    for (int i = 0; i < int'(WORDS); i++) check("ram_image", ram[64 + i], rom[i]);

    // RUN passthrough: same-cycle write, then readback.
    core_bus_address = 32'h20; core_bus_write_data = 32'hDEAD_BEEF; core_bus_write = 1'b1;
    #1;
    check("pt_addr",  bus_address, 32'h20);
    check("pt_wdata", bus_write_data, 32'hDEAD_BEEF);
    check("pt_write", 32'(bus_write), 32'h1);
    check("pt_read0", 32'(bus_read), 32'h0);
    step(1);
    check("pt_ram", ram[8], 32'hDEAD_BEEF);
    #1 core_bus_write = 1'b0; core_bus_read = 1'b1;
    #1;
    check("pt_read",  32'(bus_read), 32'h1);
    check("pt_rdata", core_bus_read_data, 32'hDEAD_BEEF);
    #1 core_bus_read = 1'b0;

    // Reload from RUN.
    push_load(WORDS, WORDS);
    loading = 1'b1; start = 1'b1;
    step(1);
    check("reload_core_reset", 32'(core_reset), 32'h1);
    check("reload_idx",        32'(word_count), 32'h0);
    check("reload_busy",       32'(busy), 32'h1);
    #1 start = 1'b0;
    step(2 * WORDS - 1);
    check("reload_done_early", 32'(done), 32'h0);
    step(1);
    check("reload_done",       32'(done), 32'h1);
    check("reload_core_rst0",  32'(core_reset), 32'h0);
    #1 loading = 1'b0;
    check("reload_drain", 32'(sbq.size()), 32'h0);

    // Corrupted readback of word 2.
    corrupt_en = 1'b1; corrupt_addr = DST_BASE + 32'h8;
    push_load(WORDS, 3);
    loading = 1'b1; start = 1'b1;
    step(1);
    #1 start = 1'b0;
    step(6);
    check("err_early", 32'(error), 32'h0);
    step(1);
    #1 loading = 1'b0;
    check("err_flag",       32'(error), 32'h1);
    check("err_idx",        32'(word_count), 32'h2);
    check("err_core_reset", 32'(core_reset), 32'h1);
    check("err_bus_strobe", {30'b0, bus_write, bus_read}, 32'h0);
    check("err_bus_addr",   bus_address, 32'h0);
    check("err_busy_done",  {30'b0, busy, done}, 32'h0);
    check("err_drain",      32'(sbq.size()), 32'h0);
    core_bus_address = 32'h20; core_bus_read = 1'b1; core_bus_write = 1'b1;
    #1;
    check("err_core_rdata", core_bus_read_data, 32'h0);
    check("err_gate_write", 32'(bus_write), 32'h0);
    step(3);
    check("err_hold",     32'(error), 32'h1);
    check("err_hold_idx", 32'(word_count), 32'h2);

    // Restart from ERROR, then reset in the middle of COPY.
    #1 core_bus_write = 1'b0; core_bus_read = 1'b0; corrupt_en = 1'b0;
    push_load(3, 0);
    loading = 1'b1; start = 1'b1;
    step(1);
    check("recover_error", 32'(error), 32'h0);
    check("recover_idx",   32'(word_count), 32'h0);
    #1 start = 1'b0;
    step(2);
    check("mid_idx",   32'(word_count), 32'h2);
    check("mid_write", 32'(bus_write), 32'h1);
    #1 loading = 1'b0; reset = 1'b0;
    #1;
    check("arst_write",      32'(bus_write), 32'h0);
    check("arst_read",       32'(bus_read), 32'h0);
    check("arst_core_reset", 32'(core_reset), 32'h1);
    check("arst_idx",        32'(word_count), 32'h0);
    check("arst_busy",       32'(busy), 32'h0);
    check("arst_drain",      32'(sbq.size()), 32'h0);
    step(1);
    push_load(WORDS, WORDS);
    #1 loading = 1'b1; reset = 1'b1;
    #1;
    check("rel_idle_busy",  32'(busy), 32'h0);
    check("rel_idle_write", 32'(bus_write), 32'h0);
    step(1);
    check("rel_copy_addr", bus_address, DST_BASE);
    step(2 * WORDS);
    check("rel_done", 32'(done), 32'h1);
    #1 loading = 1'b0;
    check("rel_drain", 32'(sbq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
